// File: rtl/mult_result_display.sv
// Captures the Booth multiplier's signed product on Done's rising edge, converts its magnitude
// to BCD with a bit-serial double-dabble and drives six active-low seven-segment displays.
module mult_result_display #(
    parameter int unsigned PW = 18,
    parameter int unsigned RW = 16,
    parameter int unsigned ND = 5
) (
    input  logic            clk,
    input  logic            Resetn,
    input  logic            Done,
    input  logic [PW-1:0]   Product,
    output logic            Busy,
    output logic            Valid,
    output logic            Sign,
    output logic [4*ND-1:0] Digits,
    output logic [6:0]      HEX0,
    output logic [6:0]      HEX1,
    output logic [6:0]      HEX2,
    output logic [6:0]      HEX3,
    output logic [6:0]      HEX4,
    output logic [6:0]      HEX5
);

    localparam int unsigned BW = 4 * ND;
    localparam int unsigned CW = $clog2(RW);

    typedef enum logic [1:0] {StIdle, StConv, StOut} state_e;

    state_e          r_state, w_state_next;
    logic            r_done_d;
    logic            r_sgn;
    logic [RW-1:0]   r_mag;
    logic [BW-1:0]   r_bcd;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic            r_sign;
    logic [BW-1:0]   r_digits;
    logic [6:0]      r_hex [ND];
    logic [6:0]      r_hex5;

    logic            w_start;
    logic [RW-1:0]   w_prod;
    logic [RW-1:0]   w_mag;
    logic [BW-1:0]   w_adj;
    logic [6:0]      w_hex [ND];
    logic            w_seen;
    logic            w_sign;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign w_start = Done & ~r_done_d;
    assign w_prod  = Product[RW:1];
    // Two's-complement negate; the most negative value wraps to its own unsigned magnitude.
    assign w_mag   = w_prod[RW-1] ? (~w_prod + RW'(1)) : w_prod;
    assign w_sign  = r_sgn & (r_bcd != '0);

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < int'(ND); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit shows once it or any higher digit is non-zero.
    always_comb begin
        w_seen = 1'b0;
        for (int i = int'(ND) - 1; i >= 0; i--) begin
            w_seen   = w_seen | (r_bcd[4*i +: 4] != 4'd0);
            w_hex[i] = (w_seen || i == 0) ? seg7(r_bcd[4*i +: 4]) : 7'h7F;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_next = StConv;
            StConv:  if (r_cnt == CW'(RW - 1)) w_state_next = StOut;
            StOut:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (Resetn) begin
            r_done_d <= 1'b1;
            r_sgn    <= 1'b0;
            r_mag    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_sign   <= 1'b0;
            r_digits <= '0;
            r_hex5   <= 7'h7F;
            for (int i = 0; i < int'(ND); i++) begin
                r_hex[i] <= (i == 0) ? 7'h40 : 7'h7F;
            end
        end else begin
            r_done_d <= Done;
            r_valid  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_sgn <= w_prod[RW-1];
                        r_mag <= w_mag;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                StConv: begin
                    r_bcd <= {w_adj[BW-2:0], r_mag[RW-1]};
                    r_mag <= {r_mag[RW-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                end
                StOut: begin
                    r_valid  <= 1'b1;
                    r_digits <= r_bcd;
                    r_sign   <= w_sign;
                    r_hex5   <= w_sign ? 7'h3F : 7'h7F;
                    for (int i = 0; i < int'(ND); i++) begin
                        r_hex[i] <= w_hex[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy   = (r_state != StIdle);
    assign Valid  = r_valid;
    assign Sign   = r_sign;
    assign Digits = r_digits;
    assign HEX0   = r_hex[0];
    assign HEX1   = r_hex[1];
    assign HEX2   = r_hex[2];
    assign HEX3   = r_hex[3];
    assign HEX4   = r_hex[4];
    assign HEX5   = r_hex5;

endmodule

// File: tb/tb_mult_result_display.sv
// Randomized bench for mult_result_display: a decimal-arithmetic model checked every cycle,
// plus literal expectations for the directed products.
module tb_mult_result_display;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        Done;
    logic [17:0] Product;
    logic        Busy, Valid, Sign;
    logic [19:0] Digits;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_checks = 0;
    int n_errors = 0;

    mult_result_display dut (
        .clk     (clk),
        .Resetn  (Resetn),
        .Done    (Done),
        .Product (Product),
        .Busy    (Busy),
        .Valid   (Valid),
        .Sign    (Sign),
        .Digits  (Digits),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decimal arithmetic on the captured value and a busy-cycle countdown.
    bit          m_on = 1'b0;
    bit          m_prev_done;
    int          m_remain;
    int          m_pend_val;
    bit          m_pend_sgn;
    bit          m_valid;
    int          m_val;
    bit          m_sgn;
    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(posedge clk) begin
        if (Resetn) begin
            m_on = 1'b1; m_prev_done = 1'b1; m_remain = 0;
            m_valid = 1'b0; m_val = 0; m_sgn = 1'b0;
        end else if (m_on) begin
            m_valid = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_valid = 1'b1; m_val = m_pend_val; m_sgn = m_pend_sgn;
                end
            end else if (Done && !m_prev_done) begin
                int p;
                p = int'($signed(Product[16:1]));
                m_pend_val = (p < 0) ? -p : p;
                m_pend_sgn = (p < 0);
                m_remain   = 17;
            end
            m_prev_done = Done;
        end
    end

    function automatic logic [6:0] exp_hex(input int v, input int idx);
        int div = 1;
        for (int i = 0; i < idx; i++) div *= 10;
        if (idx > 0 && v < div) return 7'h7F;
        return seg_tab[(v / div) % 10];
    endfunction

    function automatic logic [19:0] exp_bcd(input int v);
        logic [19:0] r;
        int div = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / div) % 10);
            div *= 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (m_on) begin
            chk("busy",   {31'd0, Busy},  {31'd0, m_remain > 0});
            chk("valid",  {31'd0, Valid}, {31'd0, m_valid});
            chk("sign",   {31'd0, Sign},  {31'd0, m_sgn});
            chk("digits", {12'd0, Digits}, {12'd0, exp_bcd(m_val)});
            chk("hex0", {25'd0, HEX0}, {25'd0, exp_hex(m_val, 0)});
            chk("hex1", {25'd0, HEX1}, {25'd0, exp_hex(m_val, 1)});
            chk("hex2", {25'd0, HEX2}, {25'd0, exp_hex(m_val, 2)});
            chk("hex3", {25'd0, HEX3}, {25'd0, exp_hex(m_val, 3)});
            chk("hex4", {25'd0, HEX4}, {25'd0, exp_hex(m_val, 4)});
            chk("hex5", {25'd0, HEX5}, {25'd0, m_sgn ? 7'h3F : 7'h7F});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Launch one conversion and wait (bounded) for Valid; optionally scramble Product meanwhile.
    task automatic run(input logic [17:0] p, input bit scramble);
        int k = 0;
        Done = 1'b0;
        tick(1);
        Product = p;
        Done = 1'b1;
        @(negedge clk);
        while (!Valid && k < 40) begin
            if (scramble) Product = 18'($urandom);
            @(negedge clk);
            k++;
        end
        chk("valid_seen", {31'd0, Valid}, 32'd1);
    endtask

    initial begin
        int nb, nv;
        logic [15:0] r;
        Resetn = 1'b1; Done = 1'b0; Product = '0;
        tick(3);
        Resetn = 1'b0;
        tick(1);
        chk("rst_hex0", {25'd0, HEX0}, 32'h40);
        chk("rst_hex1", {25'd0, HEX1}, 32'h7F);
        chk("rst_digits", {12'd0, Digits}, 32'h0);

        run(18'h00096, 1'b0);
        chk("t75_digits", {12'd0, Digits}, 32'h00075);
        chk("t75_hex0", {25'd0, HEX0}, 32'h12);
        chk("t75_hex1", {25'd0, HEX1}, 32'h78);
        chk("t75_hex2", {25'd0, HEX2}, 32'h7F);

        run(18'h08000, 1'b1);
        chk("t16384_digits", {12'd0, Digits}, 32'h16384);
        chk("t16384_sign", {31'd0, Sign}, 32'd0);
        chk("t16384_hex4", {25'd0, HEX4}, 32'h79);

        run(18'h38100, 1'b1);
        chk("tneg_digits", {12'd0, Digits}, 32'h16256);
        chk("tneg_sign", {31'd0, Sign}, 32'd1);
        chk("tneg_hex5", {25'd0, HEX5}, 32'h3F);
        chk("tneg_hex0", {25'd0, HEX0}, 32'h02);

        run(18'h00000, 1'b0);
        chk("tzero_digits", {12'd0, Digits}, 32'h0);
        chk("tzero_hex0", {25'd0, HEX0}, 32'h40);
        chk("tzero_hex5", {25'd0, HEX5}, 32'h7F);

        run({1'b1, 16'h8000, 1'b0}, 1'b1);
        chk("tmin_digits", {12'd0, Digits}, 32'h32768);
        chk("tmin_sign", {31'd0, Sign}, 32'd1);

        // Done held high, then a low/high glitch mid-conversion must be ignored.
        tick(40);
        Done = 1'b0;
        tick(1);
        Product = 18'h00096;
        Done = 1'b1;
        nb = 0; nv = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            nb += int'(Busy);
            nv += int'(Valid);
            if (i == 4) Done = 1'b0;
            if (i == 5) Done = 1'b1;
        end
        chk("glitch_busy_cycles", nb, 32'd17);
        chk("glitch_valid_count", nv, 32'd1);

        // Reset mid-conversion with Done high at release.
        Done = 1'b0;
        tick(1);
        Product = 18'h08000;
        Done = 1'b1;
        tick(9);
        Resetn = 1'b1;
        tick(2);
        Resetn = 1'b0;
        tick(1);
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_digits", {12'd0, Digits}, 32'h0);
        chk("rstmid_hex0", {25'd0, HEX0}, 32'h40);
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            nv += int'(Valid);
        end
        chk("rstmid_no_valid", nv, 32'd0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       r = 16'h0000;
                1:       r = 16'h8000;
                2:       r = 16'h7FFF;
                3:       r = 16'hFFFF;
                default: r = 16'($urandom);
            endcase
            run({r[15], r, 1'($urandom)}, 1'($urandom));
            tick(int'($urandom_range(0, 3)));
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_result_display.md
Name: mult_result_display

Overview:
- Downstream consumer of the sequential Booth multiplier's result.
- Waits for the multiplier's Done to rise, then captures its 18-bit Product word and extracts the signed 16-bit product.
- Converts the product's magnitude to five BCD digits with a sequential double-dabble, one bit per clock.
- Drives six active-low seven-segment displays: five magnitude digits plus one sign digit.

Parameters:
- PW, 18, width of the multiplier Product word.
- RW, 16, width of the signed product held in Product[RW:1].
- ND, 5, number of BCD digits. Must satisfy 10^ND > 2^(RW-1).

Ports:
- clk  in  1  system clock, rising edge.
- Resetn  in  1  reset; synchronous, active-high despite the suffix.
- Done  in  1  multiplier Done; level, stays high while the multiplier is idle.
- Product  in  PW  multiplier Product; Product[16:1] = signed product, bit 0 = Booth guard bit (ignored), bit 17 = sign extension (ignored).
- Busy  out  1  conversion in progress.
- Valid  out  1  one-cycle pulse when outputs update.
- Sign  out  1  1 = product negative.
- Digits  out  4*ND  BCD; [19:16]=ten-thousands ... [3:0]=units.
- HEX0..HEX4  out  7 each  digit segments {g,f,e,d,c,b,a}, active-low; HEX0 = units.
- HEX5  out  7  sign segments, active-low.

Behaviour:
- Reset values:
  - Busy=0, Valid=0, Sign=0, Digits=0.
  - HEX0=7'b1000000 ("0"); HEX1..HEX5=7'h7F (blank).
  - State=IDLE, bit counter=0.
  - Done history register = 1, so a Done already high at reset release does not start a conversion.
- Edge detect: done_d <= Done every cycle in every state. Start condition is Done & ~done_d, evaluated in IDLE only.
- IDLE:
  - On the start condition, register sgn = Product[16].
  - Load mag = |Product[16:1]| as 16-bit unsigned; 0x8000 maps to magnitude 32768.
  - Clear the BCD accumulator and bit counter; go to CONV; Busy=1 from the next cycle.
- CONV (16 cycles):
  - Each cycle, every BCD nibble ≥5 gets +3.
  - Then {bcd, mag} shifts left by 1; the counter increments.
  - After the 16th shift, go to OUT.
- OUT (1 cycle):
  - Latch Digits <= bcd and Sign <= sgn.
  - Update all HEX outputs and pulse Valid=1 for this cycle only.
  - Return to IDLE; Busy=0.
- Latency: capture edge E0, shifts on E1..E16, outputs and Valid become visible after E17. Busy is high for exactly 17 cycles.
- Zero result: Sign is forced to 0 (no "-0").
- Leading-zero blanking:
  - HEX4..HEX1 are blank (7'h7F) when that digit and all higher digits are 0.
  - HEX0 always shows its digit.
- HEX5 shows "-" (7'b0111111) when Sign=1, blank otherwise.
- Segment codes, digits 0-9:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex, 7-bit)
- Done rising while Busy: ignored, not queued. done_d keeps tracking, so that edge is lost.
- Product changing during CONV: no effect; operands were captured at E0.
- Reset mid-conversion: all outputs return to reset values at the reset edge and no Valid is issued.
- Outputs hold their last value between conversions.
- All outputs are registered; no combinational path from Product or Done to any output.

Test Plan:
- Product=18'h00096 (75), Done 0->1 → after 17 cycles:
  - Valid one-cycle pulse; Digits=20'h00075; Sign=0.
  - HEX0=7'h12, HEX1=7'h78; HEX2..HEX5=7'h7F.
- Product=18'h08000 (−128×−128=16384) → Digits=20'h16384, Sign=0, HEX4=7'h79, HEX5 blank.
- Product=18'h38100 (−128×127=−16256) → Digits=20'h16256, Sign=1, HEX5=7'h3F, HEX0=7'h02.
- Product=0, Done rise → Digits=0, Sign=0, HEX0=7'h40, HEX1..HEX5=7'h7F.
- Done held high 40 cycles, then pulsed low/high at cycle 5 of a conversion → exactly one Valid; Busy high exactly 17 cycles.
- Resetn asserted after 8 CONV cycles with Done=1 at release → Busy=0, Digits=0, HEX0=7'h40, no Valid for 30 cycles.
